// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divide/remainder unit.
package div_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = $clog2(DIV_DATA_W);

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Request/result handshake bundle between the execute stage and the divider.
interface div_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  i_flush;
    logic                  i_valid;
    logic                  o_ready;
    logic [1:0]            i_op;
    logic [DATA_WIDTH-1:0] i_rs1_data;
    logic [DATA_WIDTH-1:0] i_rs2_data;
    logic [ADDR_WIDTH-1:0] i_rd_addr;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_result;
    logic [ADDR_WIDTH-1:0] o_rd_addr;
    logic                  o_busy;

    modport slave (
        input  i_flush, i_valid, i_op, i_rs1_data, i_rs2_data, i_rd_addr, i_ready,
        output o_ready, o_valid, o_result, o_rd_addr, o_busy
    );

    modport master (
        output i_flush, i_valid, i_op, i_rs1_data, i_rs2_data, i_rd_addr, i_ready,
        input  o_ready, o_valid, o_result, o_rd_addr, o_busy
    );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left and try to subtract the divisor.
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic [DATA_WIDTH-1:0] quo_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic [DATA_WIDTH-1:0] quo_o
);
    localparam int W = DATA_WIDTH;

    // rem < divisor keeps the true difference inside a signed W+1 range
    logic signed [W:0] trial;

    assign trial = signed'({rem_i, quo_i[W-1]} - {1'b0, divisor_i});

    always_comb begin
        if (trial >= 0) begin
            rem_o = trial[W-1:0];
            quo_o = {quo_i[W-2:0], 1'b1};
        end else begin
            rem_o = {rem_i[W-2:0], quo_i[W-1]};
            quo_o = {quo_i[W-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: one quotient bit per cycle, sign fix-up
// on magnitudes, divide-by-zero and signed overflow resolved at accept.
module div_unit
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DATA_W,
    parameter int ADDR_WIDTH = 5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    div_unit_if.slave   bus
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [W-1:0]          result_q, result_d;
    logic [ADDR_WIDTH-1:0] rd_out_q, rd_out_d;

    logic [W-1:0]          rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    div_op_e               op_q, op_d;
    logic                  qneg_q, qneg_d, rneg_q, rneg_d;

    logic [W-1:0]          step_rem, step_quo;

    div_op_e               op_in;
    logic                  signed_in, rem_sel_in, s1_in, s2_in, zero_in, ovf_in;
    logic [W-1:0]          special_in;

    function automatic logic [W-1:0] negate_if(input logic signed [W-1:0] v, input logic neg);
        logic signed [W-1:0] neg_v;
        neg_v = -v;
        return neg ? $unsigned(neg_v) : $unsigned(v);
    endfunction

    div_step #(.DATA_WIDTH(W)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Accept-time decode of the incoming request
    always_comb begin
        op_in      = div_op_e'(bus.i_op);
        signed_in  = (op_in == OP_DIV) || (op_in == OP_REM);
        rem_sel_in = (op_in == OP_REM) || (op_in == OP_REMU);
        s1_in      = signed_in && bus.i_rs1_data[W-1];
        s2_in      = signed_in && bus.i_rs2_data[W-1];
        zero_in    = (bus.i_rs2_data == '0);
        ovf_in     = signed_in && (bus.i_rs1_data == MIN_NEG) && (bus.i_rs2_data == '1);
        if (zero_in) begin
            special_in = rem_sel_in ? bus.i_rs1_data : '1;
        end else begin
            special_in = rem_sel_in ? '0 : MIN_NEG;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        rd_d     = rd_q;
        op_d     = op_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_valid && !bus.i_flush) begin
                    op_d = op_in;
                    rd_d = bus.i_rd_addr;
                    if (zero_in || ovf_in) begin
                        result_d = special_in;
                        rd_out_d = bus.i_rd_addr;
                        state_d  = S_DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = negate_if(bus.i_rs1_data, s1_in);
                        dvs_d   = negate_if(bus.i_rs2_data, s2_in);
                        qneg_d  = s1_in ^ s2_in;
                        rneg_d  = s1_in;
                        cnt_d   = CNT_W'(W - 1);
                        state_d = S_CALC;
                    end
                end
            end
            // One quotient bit per edge
            S_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // Sign correction and result selection
            S_FIX: begin
                if ((op_q == OP_REM) || (op_q == OP_REMU)) begin
                    result_d = negate_if(rem_q, rneg_q);
                end else begin
                    result_d = negate_if(quo_q, qneg_q);
                end
                rd_out_d = rd_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (bus.i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.i_flush && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    // Working datapath needs no reset: it is always loaded at accept
    always_ff @(posedge i_clk) begin
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        dvs_q  <= dvs_d;
        rd_q   <= rd_d;
        op_q   <= op_d;
        qneg_q <= qneg_d;
        rneg_q <= rneg_d;
    end

    assign bus.o_ready   = (state_q == S_IDLE);
    assign bus.o_busy    = (state_q != S_IDLE);
    assign bus.o_valid   = (state_q == S_DONE);
    assign bus.o_result  = result_q;
    assign bus.o_rd_addr = rd_out_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, corner sequences and
// random operations against an arithmetic reference model.
module tb_div_unit;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    div_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dif ();

    div_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // RISC-V M-extension semantics computed with native arithmetic
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        logic is_rem;
        logic is_sgn;
        is_rem = op[1];
        is_sgn = !op[0];
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
        if (is_sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : a;
            return is_rem ? 32'(sa % sb) : 32'(sa / sb);
        end
        return is_rem ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 0;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 33;
    endfunction

    // lat = edges after the accepting edge until o_valid is seen (0 = valid right after accept)
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                          output int lat, output int busy_gaps);
        dif.i_op       = op;
        dif.i_rs1_data = a;
        dif.i_rs2_data = b;
        dif.i_rd_addr  = rd;
        dif.i_valid    = 1'b1;
        @(posedge clk);
        #1;
        dif.i_valid    = 1'b0;
        dif.i_op       = 2'($urandom);
        dif.i_rs1_data = $urandom;
        dif.i_rs2_data = $urandom;
        dif.i_rd_addr  = 5'($urandom);
        lat       = 0;
        busy_gaps = dif.o_busy ? 0 : 1;
        while (!dif.o_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (!dif.o_valid && !dif.o_busy) busy_gaps++;
        end
        res = dif.o_result;
        rdo = dif.o_rd_addr;
        dif.i_ready = 1'b1;
        @(posedge clk);
        #1;
        dif.i_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        logic [4:0]  rdo;
        logic [31:0] held;
        int          lat;
        int          gaps;
        int          vcount;

        n_cmp  = 0;
        n_fail = 0;

        vecs[0]  = '{2'b00, 32'hFFFF_FFF9, 32'd2,          5'd5,  32'hFFFF_FFFD, 33};
        vecs[1]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,          5'd6,  32'hFFFF_FFFF, 33};
        vecs[2]  = '{2'b01, 32'hFFFF_FFFF, 32'd1,          5'd7,  32'hFFFF_FFFF, 33};
        vecs[3]  = '{2'b11, 32'd100,       32'd7,          5'd8,  32'd2,         33};
        vecs[4]  = '{2'b01, 32'd3,         32'd10,         5'd9,  32'd0,         33};
        vecs[5]  = '{2'b00, 32'd5,         32'd0,          5'd10, 32'hFFFF_FFFF, 0};
        vecs[6]  = '{2'b10, 32'd5,         32'd0,          5'd11, 32'd5,         0};
        vecs[7]  = '{2'b11, 32'h8000_0000, 32'd0,          5'd12, 32'h8000_0000, 0};
        vecs[8]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF,  5'd13, 32'h8000_0000, 0};
        vecs[9]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  5'd14, 32'd0,         0};
        vecs[10] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF,  5'd15, 32'd0,         33};
        vecs[11] = '{2'b00, 32'd100,       32'hFFFF_FFFD,  5'd16, 32'hFFFF_FFDF, 33};
        vecs[12] = '{2'b01, 32'hFFFF_FFFF, 32'h8000_0001,  5'd17, 32'd1,         33};
        vecs[13] = '{2'b11, 32'hFFFF_FFFF, 32'h8000_0001,  5'd18, 32'h7FFF_FFFE, 33};
        vecs[14] = '{2'b10, 32'hFFFF_FF9C, 32'h0000_0007,  5'd31, 32'hFFFF_FFFE, 33};

        dif.i_flush    = 1'b0;
        dif.i_valid    = 1'b0;
        dif.i_ready    = 1'b0;
        dif.i_op       = 2'b00;
        dif.i_rs1_data = '0;
        dif.i_rs2_data = '0;
        dif.i_rd_addr  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_valid",  {31'd0, dif.o_valid}, 32'd0);
        check("reset_ready",  {31'd0, dif.o_ready}, 32'd1);
        check("reset_busy",   {31'd0, dif.o_busy},  32'd0);
        check("reset_result", dif.o_result,         32'd0);
        check("reset_rd",     {27'd0, dif.o_rd_addr}, 32'd0);

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, res, rdo, lat, gaps);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_rd", i), {27'd0, rdo}, {27'd0, vecs[i].rd});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_busy_gaps", i), gaps, 32'd0);
            check($sformatf("vec%0d_ready_after", i), {31'd0, dif.o_ready}, 32'd1);
        end

        // Backpressure in DONE with a competing request on the input side
        run_op(2'b00, 32'd100, 32'd7, 5'd9, res, rdo, lat, gaps);
        dif.i_op       = 2'b00;
        dif.i_rs1_data = 32'd100;
        dif.i_rs2_data = 32'd7;
        dif.i_rd_addr  = 5'd9;
        dif.i_valid    = 1'b1;
        @(posedge clk);
        #1;
        dif.i_op       = 2'b01;
        dif.i_rs1_data = 32'd50;
        dif.i_rs2_data = 32'd5;
        dif.i_rd_addr  = 5'd3;
        lat = 0;
        while (!dif.o_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_latency", lat, 32'd33);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_valid", k),  {31'd0, dif.o_valid}, 32'd1);
            check($sformatf("bp%0d_result", k), dif.o_result, 32'd14);
            check($sformatf("bp%0d_rd", k),     {27'd0, dif.o_rd_addr}, 32'd9);
            check($sformatf("bp%0d_ready", k),  {31'd0, dif.o_ready}, 32'd0);
        end
        dif.i_valid = 1'b0;
        dif.i_ready = 1'b1;
        @(posedge clk);
        #1;
        dif.i_ready = 1'b0;
        check("bp_release_valid", {31'd0, dif.o_valid}, 32'd0);
        check("bp_release_ready", {31'd0, dif.o_ready}, 32'd1);
        run_op(2'b01, 32'd50, 32'd5, 5'd3, res, rdo, lat, gaps);
        check("bp_next_result", res, 32'd10);
        check("bp_next_rd", {27'd0, rdo}, 32'd3);

        // Flush during CALC iteration 10
        held = dif.o_result;
        dif.i_op       = 2'b00;
        dif.i_rs1_data = 32'd1000;
        dif.i_rs2_data = 32'd3;
        dif.i_rd_addr  = 5'd7;
        dif.i_valid    = 1'b1;
        @(posedge clk);
        #1;
        dif.i_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        dif.i_flush = 1'b1;
        @(posedge clk);
        #1;
        dif.i_flush = 1'b0;
        check("flush_busy",  {31'd0, dif.o_busy},  32'd0);
        check("flush_ready", {31'd0, dif.o_ready}, 32'd1);
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (dif.o_valid) vcount++;
        end
        check("flush_no_valid", vcount, 32'd0);
        check("flush_result_held", dif.o_result, held);

        // Flush coinciding with a request blocks the accept
        dif.i_op       = 2'b01;
        dif.i_rs1_data = 32'd9;
        dif.i_rs2_data = 32'd3;
        dif.i_valid    = 1'b1;
        dif.i_flush    = 1'b1;
        @(posedge clk);
        #1;
        dif.i_valid = 1'b0;
        dif.i_flush = 1'b0;
        check("flush_accept_busy", {31'd0, dif.o_busy}, 32'd0);

        // Flush while a special-case result waits in DONE
        dif.i_op       = 2'b10;
        dif.i_rs1_data = 32'd5;
        dif.i_rs2_data = 32'd0;
        dif.i_rd_addr  = 5'd4;
        dif.i_valid    = 1'b1;
        @(posedge clk);
        #1;
        dif.i_valid = 1'b0;
        check("done_flush_pre_valid",  {31'd0, dif.o_valid}, 32'd1);
        check("done_flush_pre_result", dif.o_result, 32'd5);
        dif.i_flush = 1'b1;
        @(posedge clk);
        #1;
        dif.i_flush = 1'b0;
        check("done_flush_valid",  {31'd0, dif.o_valid}, 32'd0);
        check("done_flush_ready",  {31'd0, dif.o_ready}, 32'd1);
        check("done_flush_result", dif.o_result, 32'd5);

        // Reset in the middle of a calculation
        dif.i_op       = 2'b01;
        dif.i_rs1_data = 32'hFFFF_FFFF;
        dif.i_rs2_data = 32'd3;
        dif.i_rd_addr  = 5'd21;
        dif.i_valid    = 1'b1;
        @(posedge clk);
        #1;
        dif.i_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_valid",  {31'd0, dif.o_valid}, 32'd0);
        check("rst_mid_ready",  {31'd0, dif.o_ready}, 32'd1);
        check("rst_mid_busy",   {31'd0, dif.o_busy},  32'd0);
        check("rst_mid_result", dif.o_result, 32'd0);
        check("rst_mid_rd",     {27'd0, dif.o_rd_addr}, 32'd0);
        run_op(2'b00, 32'd100, 32'hFFFF_FFFD, 5'd12, res, rdo, lat, gaps);
        check("post_rst_result",  res, 32'hFFFF_FFDF);
        check("post_rst_latency", lat, 32'd33);

        // Random operations against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  rd;
            op = 2'($urandom);
            a  = $urandom;
            rd = 5'($urandom);
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2, 3: b = $urandom_range(1, 15);
                4: b = 32'hFFFF_FFFF - $urandom_range(0, 15);
                default: b = $urandom;
            endcase
            run_op(op, a, b, rd, res, rdo, lat, gaps);
            check($sformatf("rnd%0d_result op%0d %h/%h", i, op, a, b), res, ref_div(op, a, b));
            check($sformatf("rnd%0d_rd", i), {27'd0, rdo}, {27'd0, rd});
            check($sformatf("rnd%0d_latency", i), lat, ref_lat(op, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
